nec_ir_rx: RTL and testbench

Synthesizable NEC infrared frame receiver, the counterpart of the NEC transmitter bus-functional model used in the IR testbenches. It samples the raw IR line, measures active and idle segment lengths in quarter-ticks (1 tick = 562.5 us nominal, programmable), and decodes start, 32 data bits and stop into address/command bytes. It also decodes repeat codes. It sits in the peripheral subsystem behind a register wrapper that exposes the config and result ports.

---
 rtl/nec_ir_rx_if.sv | 25 ++
 rtl/nec_ir_rx.sv | 120 ++++++++++++
 tb/tb_nec_ir_rx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/nec_ir_rx_if.sv
// nec_ir_rx_if: config and result bundle between the NEC IR receiver and its register wrapper
//   master (register wrapper): drives cfg_*, rx_ack; reads rx_* results
//   slave  (nec_ir_rx):        reads cfg_*, rx_ack; drives rx_* results
interface nec_ir_rx_if;
  logic        cfg_en;
  logic        cfg_polarity;
  logic [15:0] cfg_qdiv;
  logic        cfg_chk_en;
  logic        rx_ack;
  logic        rx_valid;
  logic [7:0]  rx_addr;
  logic [7:0]  rx_data;
  logic        rx_repeat;
  logic        rx_overrun;
  logic        rx_err;
  logic        rx_busy;
  modport master (
    output cfg_en, cfg_polarity, cfg_qdiv, cfg_chk_en, rx_ack,
    input  rx_valid, rx_addr, rx_data, rx_repeat, rx_overrun, rx_err, rx_busy
  );
  modport slave (
    input  cfg_en, cfg_polarity, cfg_qdiv, cfg_chk_en, rx_ack,
    output rx_valid, rx_addr, rx_data, rx_repeat, rx_overrun, rx_err, rx_busy
  );
endinterface

// File: rtl/nec_ir_rx.sv
// nec_ir_rx: NEC infrared frame receiver measuring mark/space lengths in quarter-ticks
//   mclk    system clock
//   reset_n asynchronous active-low reset
//   ir_in   raw asynchronous IR line
//   bus     config inputs (cfg_en, cfg_polarity, cfg_qdiv, cfg_chk_en, rx_ack) and
//           results (rx_valid, rx_addr, rx_data, rx_repeat, rx_overrun, rx_err, rx_busy)
module nec_ir_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int LEN_W       = 8
) (
  input  logic         mclk,
  input  logic         reset_n,
  input  logic         ir_in,
  nec_ir_rx_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, START_ACT, START_IDLE, BIT_ACT, BIT_IDLE, STOP_ACT, DONE} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   act, act_q, edg, strobe;
  logic [15:0]            pre;
  logic [LEN_W-1:0]       len;
  logic [5:0]             cnt;
  logic [31:0]            sr;
  logic                   rep;
  int                     lv, mx;
  logic                   frm, rpt, b0, b1, win, tmo, chk_bad;
  assign act     = sync_q[SYNC_STAGES-1] == bus.cfg_polarity;
  assign edg     = act != act_q;
  assign strobe  = pre == bus.cfg_qdiv;
  assign lv      = int'(len);
  assign frm     = lv >= 28 && lv <= 36;
  assign rpt     = lv >= 14 && lv <= 18;
  assign b0      = lv >= 2 && lv <= 6;
  assign b1      = lv >= 10 && lv <= 14;
  assign chk_bad = bus.cfg_chk_en && (sr[15:8] != ~sr[7:0] || sr[31:24] != ~sr[23:16]);
  assign bus.rx_busy = state != IDLE;
  // Segments alternate, so the state alone tells which segment len is measuring.
  always_comb begin
    win = state == START_ACT  ? (lv >= 56 && lv <= 72) :
          state == START_IDLE ? (frm || rpt) :
          state == BIT_IDLE   ? (b0 || b1) : b0;
    mx  = state == START_ACT ? 72 : state == START_IDLE ? 36 : state == BIT_IDLE ? 14 : 6;
    tmo = lv > mx;
  end
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      sync_q         <= '0;
      act_q          <= 1'b0;
      pre            <= '0;
      len            <= '0;
      cnt            <= '0;
      sr             <= '0;
      rep            <= 1'b0;
      bus.rx_valid   <= 1'b0;
      bus.rx_addr    <= '0;
      bus.rx_data    <= '0;
      bus.rx_repeat  <= 1'b0;
      bus.rx_overrun <= 1'b0;
      bus.rx_err     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ir_in};
      act_q      <= act;
      bus.rx_err <= 1'b0;
      if (bus.rx_ack) begin
        bus.rx_valid   <= 1'b0;
        bus.rx_overrun <= 1'b0;
      end
      if (!bus.cfg_en) begin
        state <= IDLE;
        pre   <= '0;
        len   <= '0;
        cnt   <= '0;
      end else begin
        pre <= (edg || strobe) ? '0 : pre + 1'b1;
        len <= edg ? '0 : (strobe && len != '1) ? len + 1'b1 : len;
        if (state == IDLE) begin
          if (edg && act) state <= START_ACT;
        end else if (state == DONE) begin
          state <= IDLE;
        end else if (edg && win) begin
          case (state)
            START_ACT:  state <= START_IDLE;
            START_IDLE: begin
              cnt   <= '0;
              rep   <= rpt;
              state <= rpt ? STOP_ACT : BIT_ACT;
            end
            BIT_ACT:    state <= BIT_IDLE;
            BIT_IDLE:   begin
              sr    <= {b1, sr[31:1]};
              cnt   <= cnt + 6'd1;
              state <= cnt == 6'd31 ? STOP_ACT : BIT_ACT;
            end
            STOP_ACT:   begin
              // Result is committed on the stop edge itself so rx_valid lands SYNC_STAGES+1 cycles after the line goes idle.
              if (!rep && chk_bad) begin
                bus.rx_err <= 1'b1;
                state      <= IDLE;
              end else begin
                state          <= DONE;
                bus.rx_valid   <= 1'b1;
                bus.rx_repeat  <= rep;
                bus.rx_overrun <= !bus.rx_ack && (bus.rx_valid || bus.rx_overrun);
                if (!rep) begin
                  bus.rx_addr <= sr[7:0];
                  bus.rx_data <= sr[23:16];
                end
              end
            end
            default:    state <= IDLE;
          endcase
        end else if (edg || tmo) begin
          bus.rx_err <= 1'b1;
          state      <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_nec_ir_rx.sv
// tb_nec_ir_rx: table-driven frame vectors plus hand sequences for repeat, timeout and reset
module tb_nec_ir_rx;
  logic mclk = 1'b0;
  logic reset_n = 1'b0;
  logic ir_in = 1'b1;
  logic pol = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   errs = 0;
  int   e0;
  nec_ir_rx_if bus();
  nec_ir_rx #(.SYNC_STAGES(2), .LEN_W(8)) dut (.mclk(mclk), .reset_n(reset_n), .ir_in(ir_in), .bus(bus));
  always #5 mclk = ~mclk;
  always @(negedge mclk) if (bus.rx_err) errs++;
  typedef struct {
    logic       p;
    logic       chk;
    logic [7:0] a;
    logic [7:0] d;
    int         flip;
    logic       ack;
    logic       ev;
    logic [7:0] ea;
    logic [7:0] ed;
    logic       eovr;
    int         eerr;
  } vec_t;
  vec_t v[6];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  task automatic seg(input logic a, input int ticks);
    ir_in = a ? pol : ~pol;
    #(ticks * 400);
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] d, input int flip);
    logic [31:0] w;
    w = {~d, d, ~a, a};
    if (flip >= 0) w[flip] = ~w[flip];
    seg(1'b1, 16);
    seg(1'b0, 8);
    for (int i = 0; i < 32; i++) begin
      seg(1'b1, 1);
      seg(1'b0, w[i] ? 3 : 1);
    end
    seg(1'b1, 1);
    ir_in = ~pol;
  endtask
  task automatic cfg(input logic p, input logic c);
    bus.cfg_en       = 1'b0;
    pol              = p;
    bus.cfg_polarity = p;
    bus.cfg_chk_en   = c;
    ir_in            = ~p;
    #100;
    bus.cfg_en = 1'b1;
    #100;
  endtask
  task automatic ack();
    bus.rx_ack = 1'b1;
    #10;
    bus.rx_ack = 1'b0;
  endtask
  initial begin
    v[0] = '{1'b0, 1'b1, 8'h5A, 8'hC3, -1, 1'b1, 1'b1, 8'h5A, 8'hC3, 1'b0, 0};
    v[1] = '{1'b1, 1'b1, 8'h00, 8'hFF, -1, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b0, 0};
    v[2] = '{1'b0, 1'b1, 8'h5A, 8'hC3, 20, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1};
    v[3] = '{1'b0, 1'b0, 8'h5A, 8'hC3, 20, 1'b1, 1'b1, 8'h5A, 8'hD3, 1'b0, 0};
    v[4] = '{1'b0, 1'b1, 8'h11, 8'h22, -1, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 0};
    v[5] = '{1'b0, 1'b1, 8'h33, 8'h44, -1, 1'b0, 1'b1, 8'h33, 8'h44, 1'b1, 0};
    bus.cfg_en       = 1'b0;
    bus.cfg_polarity = 1'b0;
    bus.cfg_qdiv     = 16'd9;
    bus.cfg_chk_en   = 1'b1;
    bus.rx_ack       = 1'b0;
    @(posedge mclk);
    #2;
    #20;
    chk("rst_valid", bus.rx_valid, 0);
    chk("rst_addr", bus.rx_addr, 0);
    chk("rst_data", bus.rx_data, 0);
    chk("rst_repeat", bus.rx_repeat, 0);
    chk("rst_overrun", bus.rx_overrun, 0);
    chk("rst_err", bus.rx_err, 0);
    chk("rst_busy", bus.rx_busy, 0);
    reset_n = 1'b1;
    #100;
    for (int k = 0; k < 6; k++) begin
      cfg(v[k].p, v[k].chk);
      if (v[k].ack) ack();
      e0 = errs;
      send(v[k].a, v[k].d, v[k].flip);
      if (v[k].ack && v[k].ev) begin
        repeat (3) @(negedge mclk);
        chk($sformatf("v%0d_lat_early", k), bus.rx_valid, 0);
        @(negedge mclk);
        chk($sformatf("v%0d_lat_rise", k), bus.rx_valid, 1);
        #7;
      end else begin
        #40;
      end
      #300;
      chk($sformatf("v%0d_valid", k), bus.rx_valid, v[k].ev);
      chk($sformatf("v%0d_addr", k), bus.rx_addr, v[k].ea);
      chk($sformatf("v%0d_data", k), bus.rx_data, v[k].ed);
      chk($sformatf("v%0d_repeat", k), bus.rx_repeat, 0);
      chk($sformatf("v%0d_overrun", k), bus.rx_overrun, v[k].eovr);
      chk($sformatf("v%0d_errs", k), errs - e0, v[k].eerr);
      chk($sformatf("v%0d_busy", k), bus.rx_busy, 0);
    end
    ack();
    #20;
    chk("ack_valid", bus.rx_valid, 0);
    chk("ack_overrun", bus.rx_overrun, 0);
    cfg(1'b0, 1'b1);
    send(8'h5A, 8'hC3, -1);
    #300;
    ack();
    #20;
    chk("pre_rep_valid", bus.rx_valid, 0);
    e0 = errs;
    seg(1'b1, 16);
    seg(1'b0, 4);
    seg(1'b1, 1);
    ir_in = ~pol;
    #300;
    chk("rep_valid", bus.rx_valid, 1);
    chk("rep_repeat", bus.rx_repeat, 1);
    chk("rep_addr", bus.rx_addr, 8'h5A);
    chk("rep_data", bus.rx_data, 8'hC3);
    chk("rep_errs", errs - e0, 0);
    e0 = errs;
    seg(1'b1, 16);
    seg(1'b0, 8);
    seg(1'b1, 1);
    seg(1'b0, 3);
    chk("tmo_not_yet", errs - e0, 0);
    chk("tmo_busy_before", bus.rx_busy, 1);
    seg(1'b0, 3);
    chk("tmo_err", errs - e0, 1);
    chk("tmo_busy", bus.rx_busy, 0);
    chk("tmo_valid_kept", bus.rx_valid, 1);
    seg(1'b1, 16);
    seg(1'b0, 8);
    for (int i = 0; i < 10; i++) begin
      seg(1'b1, 1);
      seg(1'b0, 1);
    end
    seg(1'b1, 1);
    chk("mid_busy", bus.rx_busy, 1);
    reset_n = 1'b0;
    #3;
    chk("mid_rst_valid", bus.rx_valid, 0);
    chk("mid_rst_addr", bus.rx_addr, 0);
    chk("mid_rst_data", bus.rx_data, 0);
    chk("mid_rst_repeat", bus.rx_repeat, 0);
    chk("mid_rst_busy", bus.rx_busy, 0);
    #7;
    bus.cfg_en = 1'b0;
    ir_in = ~pol;
    #100;
    reset_n = 1'b1;
    #100;
    bus.cfg_en = 1'b1;
    #100;
    e0 = errs;
    send(8'hA5, 8'h3C, -1);
    #340;
    chk("post_valid", bus.rx_valid, 1);
    chk("post_addr", bus.rx_addr, 8'hA5);
    chk("post_data", bus.rx_data, 8'h3C);
    chk("post_overrun", bus.rx_overrun, 0);
    chk("post_errs", errs - e0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
